// File: rtl/muxf_scan_capture.sv
// Scans a 2**SEL_W-word bus through a 2:1 mux tree into a valid/ready output register.
// Define MUXF_SCAN_PIPE_EN to register the F7 level ahead of the final 2:1 stage.
module muxf_scan_capture #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SEL_W     = 3,
   parameter int unsigned SCAN_LAST = 7
) (
   input  logic                        C,
   input  logic                        CLR_N,
   input  logic [WIDTH*(2**SEL_W)-1:0] D,
   input  logic                        START,
   input  logic                        ABORT,
   input  logic                        O_RDY,
   output logic [WIDTH-1:0]            O,
   output logic [SEL_W-1:0]            O_IDX,
   output logic                        O_VLD,
   output logic                        BUSY,
   output logic                        DONE
);

   localparam int unsigned N = 2**SEL_W;
   localparam logic [SEL_W:0]   LAST_SEL = SCAN_LAST[SEL_W:0];
   localparam logic [SEL_W-1:0] LAST_IDX = SCAN_LAST[SEL_W-1:0];

   if ((SEL_W == 0) || (SCAN_LAST >= N)) begin : g_bad_param
      $error("muxf_scan_capture: SEL_W must be >= 1 and SCAN_LAST in 0..2**SEL_W-1");
   end

   typedef enum logic [1:0] {StIdle, StScan, StWait} state_e;

   state_e           state_q, state_d;
   logic [SEL_W:0]   sel_q, sel_d;
   logic [WIDTH-1:0] o_q;
   logic [SEL_W-1:0] idx_q;
   logic             vld_q;
   logic             done_q;

   logic [WIDTH-1:0] f7_lo, f7_hi;
   logic [WIDTH-1:0] cap_word;
   logic [SEL_W-1:0] cap_idx;
   logic             scan_ok, can_load, issue, out_load, last_acc;

   // Levels below the final one collapse in place; the last two words are the F7 outputs.
   always_comb begin : mux_tree
      logic [WIDTH-1:0] w [N];
      for (int i = 0; i < N; i++) w[i] = D[i*WIDTH +: WIDTH];
      for (int l = 0; l < SEL_W - 1; l++) begin
         for (int j = 0; j < (N >> (l + 1)); j++) begin
            w[j] = sel_q[l] ? w[2*j+1] : w[2*j];
         end
      end
      f7_lo = w[0];
      f7_hi = w[1];
   end

   assign scan_ok  = (state_q == StScan) && (sel_q <= LAST_SEL);
   assign can_load = !vld_q || O_RDY;
   assign last_acc = vld_q && O_RDY && (idx_q == LAST_IDX);

`ifdef MUXF_SCAN_PIPE_EN
   logic             stg_vld_q;
   logic [WIDTH-1:0] stg_lo_q, stg_hi_q;
   logic             stg_msb_q;
   logic [SEL_W-1:0] stg_idx_q;

   // The stage refills only when it is empty or draining into the output register.
   assign issue    = scan_ok && (!stg_vld_q || can_load);
   assign out_load = stg_vld_q && can_load;
   assign cap_word = stg_msb_q ? stg_hi_q : stg_lo_q;
   assign cap_idx  = stg_idx_q;

   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         stg_vld_q <= 1'b0;
         stg_lo_q  <= '0;
         stg_hi_q  <= '0;
         stg_msb_q <= 1'b0;
         stg_idx_q <= '0;
      end else if (ABORT) begin
         stg_vld_q <= 1'b0;
      end else if (issue) begin
         stg_vld_q <= 1'b1;
         stg_lo_q  <= f7_lo;
         stg_hi_q  <= f7_hi;
         stg_msb_q <= sel_q[SEL_W-1];
         stg_idx_q <= sel_q[SEL_W-1:0];
      end else if (out_load) begin
         stg_vld_q <= 1'b0;
      end
   end
`else
   assign issue    = scan_ok && can_load;
   assign out_load = issue;
   assign cap_word = sel_q[SEL_W-1] ? f7_hi : f7_lo;
   assign cap_idx  = sel_q[SEL_W-1:0];
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      if (ABORT) begin
         state_d = StIdle;
         sel_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (START) begin
                  state_d = StScan;
                  sel_d   = '0;
               end
            end
            StScan: begin
               if (issue) begin
                  sel_d = sel_q + {{SEL_W{1'b0}}, 1'b1};
                  if (sel_q == LAST_SEL) state_d = StWait;
               end
            end
            StWait: begin
               if (last_acc) begin
                  state_d = StIdle;
                  sel_d   = '0;
               end
            end
            default: begin
               state_d = StIdle;
               sel_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q <= StIdle;
         sel_q   <= '0;
         o_q     <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         done_q  <= !ABORT && (state_q == StWait) && last_acc;
         if (ABORT) begin
            vld_q <= 1'b0;
         end else if (out_load) begin
            o_q   <= cap_word;
            idx_q <= cap_idx;
            vld_q <= 1'b1;
         end else if (O_RDY) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign O     = o_q;
   assign O_IDX = idx_q;
   assign O_VLD = vld_q;
   assign BUSY  = (state_q != StIdle);
   assign DONE  = done_q;

endmodule
